regbank_arbiter: RTL and testbench

- Clocked arbiter sharing the single regbank access port between two requesters.
  - Read requester: decode operand fetch.
  - Write requester: ALU writeback of srcDst result.
- All requester-side and regbank-side handshakes are two-phase toggle (trigger/ready) with bundled data, matching the pipeline stages.
- Resolves read/write contention, orders read-after-write on the same register, and flags a regbank that stops responding.

---
 rtl/regbank_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_regbank_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_arbiter.sv
// regbank_arbiter
//   Shares the single regbank access port between the decode operand-fetch
//   read requester (R) and the ALU writeback write requester (W). Every
//   handshake is a two-phase toggle with bundled data.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   triggerInR/addrInR          read request toggle + bundled address
//   readyOutR/dataOutR          read done toggle + read data
//   triggerInW/addrInW/dataInW  write request toggle + bundled addr/data
//   readyOutW                   write done toggle
//   triggerOutRB/addrOutRB/dataOutRB/weOutRB   regbank access toggle + bundle
//   readyInRB/dataInRB          regbank done toggle + read data
//   busy                        high whenever the FSM is not in IDLE
//   timeoutErr                  sticky: regbank stopped responding
//
// state   | meaning
// IDLE    | wait for a pending request, pick grant, latch regbank bundle
// SETUP   | bundle stable for a cycle, then toggle triggerOutRB
// WAIT    | wait for synchronized regbank ready, count toward timeout
// CAPTURE | latch regbank read data (read grant only)
// RESP    | toggle the granted requester's ready
// ERROR   | regbank timed out; terminal until reset
module regbank_arbiter #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              triggerInR,
    input  logic [ADDR_W-1:0] addrInR,
    output logic              readyOutR,
    output logic [31:0]       dataOutR,
    input  logic              triggerInW,
    input  logic [ADDR_W-1:0] addrInW,
    input  logic [31:0]       dataInW,
    output logic              readyOutW,
    output logic              triggerOutRB,
    output logic [ADDR_W-1:0] addrOutRB,
    output logic [31:0]       dataOutRB,
    output logic              weOutRB,
    input  logic              readyInRB,
    input  logic [31:0]       dataInRB,
    output logic              busy,
    output logic              timeoutErr
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WAIT, S_CAPTURE, S_RESP, S_ERROR
    } state_e;

    logic [SYNC_STAGES-1:0] sync_r_q, sync_w_q, sync_rb_q;

    state_e            state_q, state_d;
    logic              grant_w_q, grant_w_d;   // also serves as lastGrant (0 = R)
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              trig_rb_q, trig_rb_d;
    logic [ADDR_W-1:0] addr_rb_q, addr_rb_d;
    logic [31:0]       data_rb_q, data_rb_d;
    logic              we_rb_q, we_rb_d;
    logic              ready_r_q, ready_r_d;
    logic              ready_w_q, ready_w_d;
    logic [31:0]       data_r_q, data_r_d;
    logic              tout_q, tout_d;

    logic sync_trig_r, sync_trig_w, sync_ready_rb;
    logic pend_r, pend_w, gnt_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r_q  <= '0;
            sync_w_q  <= '0;
            sync_rb_q <= '0;
        end else begin
            sync_r_q  <= {sync_r_q[SYNC_STAGES-2:0], triggerInR};
            sync_w_q  <= {sync_w_q[SYNC_STAGES-2:0], triggerInW};
            sync_rb_q <= {sync_rb_q[SYNC_STAGES-2:0], readyInRB};
        end
    end

    assign sync_trig_r   = sync_r_q[SYNC_STAGES-1];
    assign sync_trig_w   = sync_w_q[SYNC_STAGES-1];
    assign sync_ready_rb = sync_rb_q[SYNC_STAGES-1];

    assign pend_r = sync_trig_r != ready_r_q;
    assign pend_w = sync_trig_w != ready_w_q;

    // W wins when alone, on a same-address collision (read must see the
    // new value), or when R had the previous grant.
    assign gnt_w = pend_w && (!pend_r || (addrInR == addrInW) || !grant_w_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            grant_w_q <= 1'b0;
            cnt_q     <= '0;
            trig_rb_q <= 1'b0;
            addr_rb_q <= '0;
            data_rb_q <= '0;
            we_rb_q   <= 1'b0;
            ready_r_q <= 1'b0;
            ready_w_q <= 1'b0;
            data_r_q  <= '0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_w_q <= grant_w_d;
            cnt_q     <= cnt_d;
            trig_rb_q <= trig_rb_d;
            addr_rb_q <= addr_rb_d;
            data_rb_q <= data_rb_d;
            we_rb_q   <= we_rb_d;
            ready_r_q <= ready_r_d;
            ready_w_q <= ready_w_d;
            data_r_q  <= data_r_d;
            tout_q    <= tout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_w_d = grant_w_q;
        cnt_d     = cnt_q;
        trig_rb_d = trig_rb_q;
        addr_rb_d = addr_rb_q;
        data_rb_d = data_rb_q;
        we_rb_d   = we_rb_q;
        ready_r_d = ready_r_q;
        ready_w_d = ready_w_q;
        data_r_d  = data_r_q;
        tout_d    = tout_q;
        case (state_q)
            S_IDLE: begin
                if (pend_r || pend_w) begin
                    grant_w_d = gnt_w;
                    we_rb_d   = gnt_w;
                    if (gnt_w) begin
                        addr_rb_d = addrInW;
                        data_rb_d = dataInW;
                    end else begin
                        // write data bus keeps its last value on reads
                        addr_rb_d = addrInR;
                    end
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                trig_rb_d = ~trig_rb_q;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (sync_ready_rb == trig_rb_q) begin
                    state_d = S_CAPTURE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tout_d  = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                // dataInRB has been stable for SYNC_STAGES cycles by now
                if (!grant_w_q) data_r_d = dataInRB;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (grant_w_q) ready_w_d = ~ready_w_q;
                else           ready_r_d = ~ready_r_q;
                state_d = S_IDLE;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    assign readyOutR    = ready_r_q;
    assign dataOutR     = data_r_q;
    assign readyOutW    = ready_w_q;
    assign triggerOutRB = trig_rb_q;
    assign addrOutRB    = addr_rb_q;
    assign dataOutRB    = data_rb_q;
    assign weOutRB      = we_rb_q;
    assign busy         = state_q != S_IDLE;
    assign timeoutErr   = tout_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
module tb_regbank_arbiter;
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int ADDR_W         = 4;

    logic              clk, reset;
    logic              triggerInR, readyOutR, triggerInW, readyOutW;
    logic [ADDR_W-1:0] addrInR, addrInW, addrOutRB;
    logic [31:0]       dataOutR, dataInW, dataOutRB, dataInRB;
    logic              triggerOutRB, weOutRB, readyInRB, busy, timeoutErr;

    regbank_arbiter #(
        .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset),
        .triggerInR(triggerInR), .addrInR(addrInR), .readyOutR(readyOutR), .dataOutR(dataOutR),
        .triggerInW(triggerInW), .addrInW(addrInW), .dataInW(dataInW), .readyOutW(readyOutW),
        .triggerOutRB(triggerOutRB), .addrOutRB(addrOutRB), .dataOutRB(dataOutRB),
        .weOutRB(weOutRB), .readyInRB(readyInRB), .dataInRB(dataInRB),
        .busy(busy), .timeoutErr(timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              we;
        bit [ADDR_W-1:0] addr;
        bit [31:0]       data;
    } rb_t;

    rb_t       exp_rb[$];
    bit [31:0] exp_rd[$];
    int        pend_w_exp;
    int        total, bad;

    // reference register contents and round-robin memory of the model
    bit [31:0] ref_mem[16];
    bit        m_last_w;

    // regbank environment
    bit [31:0] rb_mem[16];
    bit        rb_mute;
    int        rb_delay;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // regbank model: responds to each triggerOutRB toggle after rb_delay cycles
    initial begin
        bit              seen, we_l;
        bit [ADDR_W-1:0] a_l;
        bit [31:0]       d_l;
        int              cnt;
        readyInRB = 1'b0;
        dataInRB  = '0;
        seen = 0; cnt = -1; we_l = 0; a_l = '0; d_l = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                readyInRB = 1'b0;
                seen = 0;
                cnt  = -1;
            end else begin
                if (cnt > 0) cnt--;
                else if (cnt == 0) begin
                    if (we_l) rb_mem[a_l] = d_l;
                    else      dataInRB = rb_mem[a_l];
                    readyInRB = ~readyInRB;
                    cnt = -1;
                end
                if (triggerOutRB != seen) begin
                    seen = triggerOutRB;
                    we_l = weOutRB;
                    a_l  = addrOutRB;
                    d_l  = dataOutRB;
                    cnt  = rb_mute ? -1 : rb_delay;
                end
            end
        end
    end

    // monitor / scoreboard
    initial begin
        logic        p_trig, p_rr, p_rw;
        logic [31:0] p_dout;
        rb_t         e;
        bit [31:0]   ed;
        p_trig = 0; p_rr = 0; p_rw = 0; p_dout = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                p_trig = 0; p_rr = 0; p_rw = 0; p_dout = '0;
            end else begin
                if (triggerOutRB != p_trig) begin
                    chk("rb_access_expected", exp_rb.size() != 0, 1);
                    if (exp_rb.size() != 0) begin
                        e = exp_rb.pop_front();
                        chk("rb_we", weOutRB, e.we);
                        chk("rb_addr", addrOutRB, e.addr);
                        if (e.we) chk("rb_wdata", dataOutRB, e.data);
                    end
                end
                if (readyOutR != p_rr) begin
                    chk("rd_done_expected", exp_rd.size() != 0, 1);
                    if (exp_rd.size() != 0) begin
                        ed = exp_rd.pop_front();
                        chk("rd_data", dataOutR, ed);
                        chk("rd_data_before_ready", p_dout, ed);
                    end
                end
                if (readyOutW != p_rw) begin
                    chk("wr_done_expected", pend_w_exp > 0, 1);
                    pend_w_exp--;
                end
                p_trig = triggerOutRB; p_rr = readyOutR; p_rw = readyOutW; p_dout = dataOutR;
            end
        end
    end

    task automatic model_w(bit [ADDR_W-1:0] a, bit [31:0] d, bit resp);
        exp_rb.push_back('{we: 1'b1, addr: a, data: d});
        ref_mem[a] = d;
        if (resp) pend_w_exp++;
    endtask

    task automatic model_r(bit [ADDR_W-1:0] a, bit resp);
        exp_rb.push_back('{we: 1'b0, addr: a, data: 32'h0});
        if (resp) exp_rd.push_back(ref_mem[a]);
    endtask

    task automatic issue(bit dr, bit [ADDR_W-1:0] ar, bit dw, bit [ADDR_W-1:0] aw,
                         bit [31:0] dd, bit resp);
        bit wfirst;
        @(negedge clk);
        if (dr) begin addrInR = ar; triggerInR = ~triggerInR; end
        if (dw) begin addrInW = aw; dataInW = dd; triggerInW = ~triggerInW; end
        wfirst = dw && (!dr || ar == aw || !m_last_w);
        if (wfirst) begin
            model_w(aw, dd, resp);
            if (dr) model_r(ar, resp);
            m_last_w = !dr;
        end else begin
            if (dr) model_r(ar, resp);
            if (dw) model_w(aw, dd, resp);
            m_last_w = dw;
        end
    endtask

    task automatic wait_done(string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!(readyOutR == triggerInR && readyOutW == triggerInW && !busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n < 400, 1);
    endtask

    task automatic clear_bench();
        triggerInR = 0; triggerInW = 0;
        addrInR = '0; addrInW = '0; dataInW = '0;
        exp_rb.delete(); exp_rd.delete();
        pend_w_exp = 0;
        m_last_w = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_bench();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_trigRB"}, triggerOutRB, 0);
        chk({nm, "_readyR"}, readyOutR, 0);
        chk({nm, "_readyW"}, readyOutW, 0);
        chk({nm, "_dataR"}, dataOutR, 0);
        chk({nm, "_addrRB"}, addrOutRB, 0);
        chk({nm, "_dataRB"}, dataOutRB, 0);
        chk({nm, "_weRB"}, weOutRB, 0);
        chk({nm, "_tout"}, timeoutErr, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic t0, r0, w0;
        int   n;
        total = 0; bad = 0;
        rb_mute = 0; rb_delay = 5;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            rb_mem[i]  = ref_mem[i];
        end
        ref_mem[3] = 32'h1234_5678;
        rb_mem[3]  = 32'h1234_5678;

        reset = 1'b0;
        clear_bench();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // single read with trigger latency
        t0 = triggerOutRB; w0 = readyOutW;
        issue(1, 3, 0, 0, 0, 1);
        n = 0;
        while (triggerOutRB == t0 && n < 20) begin @(negedge clk); n++; end
        chk("rd_trig_latency", n, SYNC_STAGES + 2);
        wait_done("single_read_done");
        chk("single_read_data", dataOutR, 32'h1234_5678);
        chk("single_read_no_w", readyOutW, w0);

        // single write
        issue(0, 0, 1, 7, 32'hCAFE_F00D, 1);
        wait_done("single_write_done");
        chk("write_keeps_dout", dataOutR, 32'h1234_5678);
        chk("write_reached_rb", rb_mem[7], 32'hCAFE_F00D);

        // simultaneous pairs, different addresses
        do_reset();
        issue(1, 2, 1, 5, 32'h5555_0001, 1);
        wait_done("pair1_done");
        issue(0, 0, 1, 6, 32'h6666_0002, 1);
        wait_done("pair_sep_done");
        issue(1, 2, 1, 5, 32'h5555_0003, 1);
        wait_done("pair2_done");

        // RAW hazard with lastGrant = W
        issue(0, 0, 1, 1, 32'h0101_0101, 1);
        wait_done("raw_pre_done");
        issue(1, 4, 1, 4, 32'hA5A5_A5A5, 1);
        wait_done("raw_done");
        chk("raw_read_value", dataOutR, 32'hA5A5_A5A5);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            bit dr, dw;
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!dr && !dw) dr = 1;
            rb_delay = $urandom_range(0, 6);
            issue(dr, 4'($urandom_range(8, 11)), dw, 4'($urandom_range(8, 11)), $urandom, 1);
            wait_done("rand_done");
        end
        chk("sb_rb_empty", exp_rb.size(), 0);
        chk("sb_rd_empty", exp_rd.size(), 0);
        chk("sb_wr_empty", pend_w_exp, 0);

        // timeout
        rb_mute = 1;
        t0 = triggerOutRB; r0 = readyOutR;
        issue(1, 9, 0, 0, 0, 0);
        n = 0;
        while (triggerOutRB == t0 && n < 20) begin @(negedge clk); n++; end
        chk("tout_trig_seen", n < 20, 1);
        n = 0;
        while (!timeoutErr && n < 200) begin @(negedge clk); n++; end
        chk("tout_cycles", n, TIMEOUT_CYCLES);
        chk("tout_busy", busy, 1);
        t0 = triggerOutRB;
        triggerInR = ~triggerInR;
        repeat (30) @(negedge clk);
        chk("tout_no_readyR", readyOutR, r0);
        chk("tout_no_new_trig", triggerOutRB, t0);
        chk("tout_sticky", timeoutErr, 1);
        chk("tout_busy_hold", busy, 1);
        #2 reset = 1'b0;
        #1 chk_all_zero("tout_reset");
        clear_bench();
        rb_mute = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // async reset mid-WAIT
        rb_delay = 20;
        issue(1, 3, 0, 0, 0, 1);
        repeat (8) @(negedge clk);
        chk("midwait_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("midwait_busy0", busy, 0);
        chk("midwait_trig0", triggerOutRB, 0);
        chk("midwait_readyR0", readyOutR, 0);
        chk("midwait_readyW0", readyOutW, 0);
        clear_bench();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rb_delay = 3;
        issue(1, 3, 0, 0, 0, 1);
        wait_done("post_reset_read_done");
        chk("post_reset_read", dataOutR, 32'h1234_5678);
        chk("final_rb_empty", exp_rb.size(), 0);
        chk("final_rd_empty", exp_rd.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
